game_controller: RTL and testbench
==================================

# game_controller

Top-level game sequencer for SkyHop, clocked by the 40 MHz pixel clock. It replaces the per-module test switches (`sw[6:0]`) and raw button routing. It owns the game state machine and drives the `module_en` inputs of start_screen, blocks, time_bar, character, points and end_screen. It also gates jump pulses to blocks/character, restarts the time bar on every landing, and selects the background colour.

## Interface
Parameters:
- START_DELAY_MS, 500: ms between start press and first playable cycle
- JUMP_TIMEOUT_MS, 1000: max ms in air before a forced game over
- END_HOLD_MS, 2000: ms the end screen ignores start presses
- COLOR_PERIOD, 10: landings between background colour toggles

Ports:
- clk  in  1  40 MHz clock
- rst  in  1  reset, asynchronous, active-low
- start_tick  in  1  debounced one-cycle start press
- jump_left_in / jump_right_in  in  1  debounced one-cycle jump presses
- one_ms_tick  in  1  one-cycle pulse every 1 ms
- landed  in  1  one-cycle pulse from character: jump finished on a block
- fell  in  1  one-cycle pulse from character: jump missed
- time_elapsed  in  1  level from time_bar: bar empty
- start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en  out  1 each  module enables
- jump_left_out / jump_right_out  out  1  gated jump pulses
- time_bar_start  out  1  one-cycle time bar restart
- points_clr  out  1  one-cycle score clear
- bg_color_select  out  1  background colour
- state  out  3  encoded state (debug/LED)

## Operation
- States and encodings: START=0, ARM=1, PLAY=2, AIR=3, OVER=4. Other encodings go to START on the next cycle.
- ms_cnt: 16-bit counter, cleared on every state change, +1 on one_ms_tick, saturates at 0xFFFF.
- land_cnt: 8-bit counter, cleared in ARM. It increments on accepted landings; on reaching COLOR_PERIOD it returns to 0 and toggles bg_color_select.
- START: start_screen_en=1, all other enables 0. start_tick → ARM and pulses points_clr.
- ARM: blocks_en, character_en and points_en are 1. Jumps are not forwarded. When ms_cnt == START_DELAY_MS → PLAY and pulses time_bar_start.
- PLAY: blocks_en, time_bar_en, character_en and points_en are 1.
  - Exactly one jump input → forward that input as a pulse, → AIR.
  - Both jump inputs in the same cycle → ignored.
  - time_elapsed=1 → OVER; this takes priority over a jump in the same cycle.
- AIR: same enables as PLAY; jump inputs are dropped. Priority, highest first:
  - fell → OVER
  - landed → pulse time_bar_start, update land_cnt, → PLAY
  - time_elapsed → OVER
  - ms_cnt == JUMP_TIMEOUT_MS → OVER
- OVER: end_screen_en=1 and points_en=1 (score stays visible); time_bar_en=0.
  - start_tick while ms_cnt < END_HOLD_MS → ignored.
  - start_tick once ms_cnt ≥ END_HOLD_MS → START.
- bg_color_select holds its value through OVER and START; it is cleared only by reset.

## Timing
- All outputs are registered. An input event in cycle N produces the output change and the new state in cycle N+1.
- Pulse outputs (jump_*_out, time_bar_start, points_clr) are high for exactly one cycle per event, never back-to-back.
- Enables change in the same cycle as `state`.
- Delay condition: ms_cnt reaches K on the K-th one_ms_tick after entry. The transition follows one cycle later, so the delay is K ms ±1 tick period.
- Reset (asynchronous, active-low): state=START, start_screen_en=1, all other outputs 0, ms_cnt=0, land_cnt=0, bg_color_select=0.
- Reset asserted mid-game: all pulses stop immediately and the block resumes in START after release.
- one_ms_tick coinciding with a transition: the counter clears; that tick is not counted.

## Test plan
- Reset low for 5 cycles, then release → state=0, only start_screen_en=1, no pulses on any output.
- start_tick → points_clr for 1 cycle, state=1. After 500 ms ticks → time_bar_start pulse, state=2.
- In PLAY, pulse jump_left_in → jump_left_out for 1 cycle, state=3. A second jump_right_in while in AIR → no output. Then landed → time_bar_start, state=2.
- In PLAY, assert jump_left_in and jump_right_in together → no output, state stays 2. In AIR, assert landed and time_elapsed together → state=2 (landed wins).
- Perform 10 jump/land cycles → bg_color_select toggles 0→1 on the 10th landing, land_cnt returns to 0. In AIR with no landed for 1000 ticks → state=4.
- In OVER, start_tick at 1999 ms → ignored. start_tick at 2000 ms → state=0, bg_color_select unchanged.

Source files
------------

// File: rtl/game_controller.sv
// SkyHop game sequencer: owns the START/ARM/PLAY/AIR/OVER flow, drives the
// per-module enables, gates jump pulses and tracks landings for the background colour.
module game_controller #(
    parameter int START_DELAY_MS  = 500,
    parameter int JUMP_TIMEOUT_MS = 1000,
    parameter int END_HOLD_MS     = 2000,
    parameter int COLOR_PERIOD    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_tick,
    input  logic       jump_left_in,
    input  logic       jump_right_in,
    input  logic       one_ms_tick,
    input  logic       landed,
    input  logic       fell,
    input  logic       time_elapsed,
    output logic       start_screen_en,
    output logic       blocks_en,
    output logic       time_bar_en,
    output logic       character_en,
    output logic       points_en,
    output logic       end_screen_en,
    output logic       jump_left_out,
    output logic       jump_right_out,
    output logic       time_bar_start,
    output logic       points_clr,
    output logic       bg_color_select,
    output logic [2:0] state
);

    // Handshake note: every input is a one-cycle pulse (time_elapsed is a level)
    // and is consumed in the cycle it is seen; there is no back-pressure.

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_ARM   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_AIR   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [15:0] DELAY_LIM   = 16'(START_DELAY_MS);
    localparam logic [15:0] TIMEOUT_LIM = 16'(JUMP_TIMEOUT_MS);
    localparam logic [15:0] HOLD_LIM    = 16'(END_HOLD_MS);
    localparam logic [7:0]  COLOR_LIM   = 8'(COLOR_PERIOD);

    state_t      cur_state;
    state_t      nxt_state;
    logic [15:0] ms_cnt;
    logic [7:0]  land_cnt;
    logic        nxt_jump_left;
    logic        nxt_jump_right;
    logic        nxt_time_bar_start;
    logic        nxt_points_clr;
    logic        land_event;

    // Enable pattern {start_screen, blocks, time_bar, character, points, end_screen}.
    function automatic logic [5:0] enables_for(input state_t s);
        case (s)
            ST_START: enables_for = 6'b100000;
            ST_ARM:   enables_for = 6'b010110;
            ST_PLAY:  enables_for = 6'b011110;
            ST_AIR:   enables_for = 6'b011110;
            ST_OVER:  enables_for = 6'b000011;
            default:  enables_for = 6'b100000;
        endcase
    endfunction

    always_comb begin
        nxt_state          = cur_state;
        nxt_jump_left      = 1'b0;
        nxt_jump_right     = 1'b0;
        nxt_time_bar_start = 1'b0;
        nxt_points_clr     = 1'b0;
        land_event         = 1'b0;
        case (cur_state)
            ST_START: begin
                if (start_tick) begin
                    nxt_state      = ST_ARM;
                    nxt_points_clr = 1'b1;
                end
            end
            ST_ARM: begin
                if (ms_cnt == DELAY_LIM) begin
                    nxt_state          = ST_PLAY;
                    nxt_time_bar_start = 1'b1;
                end
            end
            ST_PLAY: begin
                // An empty time bar beats a jump arriving in the same cycle.
                if (time_elapsed) begin
                    nxt_state = ST_OVER;
                end else if (jump_left_in ^ jump_right_in) begin
                    nxt_state      = ST_AIR;
                    nxt_jump_left  = jump_left_in;
                    nxt_jump_right = jump_right_in;
                end
            end
            ST_AIR: begin
                if (fell) begin
                    nxt_state = ST_OVER;
                end else if (landed) begin
                    nxt_state          = ST_PLAY;
                    nxt_time_bar_start = 1'b1;
                    land_event         = 1'b1;
                end else if (time_elapsed) begin
                    nxt_state = ST_OVER;
                end else if (ms_cnt == TIMEOUT_LIM) begin
                    nxt_state = ST_OVER;
                end
            end
            ST_OVER: begin
                if (start_tick && (ms_cnt >= HOLD_LIM)) begin
                    nxt_state = ST_START;
                end
            end
            default: nxt_state = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state       <= ST_START;
            ms_cnt          <= 16'd0;
            land_cnt        <= 8'd0;
            bg_color_select <= 1'b0;
            jump_left_out   <= 1'b0;
            jump_right_out  <= 1'b0;
            time_bar_start  <= 1'b0;
            points_clr      <= 1'b0;
            {start_screen_en, blocks_en, time_bar_en,
             character_en, points_en, end_screen_en} <= 6'b100000;
        end else begin
            cur_state <= nxt_state;

            // A tick landing on a state change is dropped along with the old count.
            if (nxt_state != cur_state) begin
                ms_cnt <= 16'd0;
            end else if (one_ms_tick && (ms_cnt != 16'hFFFF)) begin
                ms_cnt <= ms_cnt + 16'd1;
            end

            if (cur_state == ST_ARM) begin
                land_cnt <= 8'd0;
            end else if (land_event) begin
                if ((land_cnt + 8'd1) >= COLOR_LIM) begin
                    land_cnt        <= 8'd0;
                    bg_color_select <= ~bg_color_select;
                end else begin
                    land_cnt <= land_cnt + 8'd1;
                end
            end

            jump_left_out  <= nxt_jump_left;
            jump_right_out <= nxt_jump_right;
            time_bar_start <= nxt_time_bar_start;
            points_clr     <= nxt_points_clr;
            {start_screen_en, blocks_en, time_bar_en,
             character_en, points_en, end_screen_en} <= enables_for(nxt_state);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: a cycle model of the game rules feeds an expected
// queue checked every cycle, plus literal checks along a directed game script.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_tick = 1'b0;
    logic       jump_left_in = 1'b0;
    logic       jump_right_in = 1'b0;
    logic       one_ms_tick = 1'b0;
    logic       landed = 1'b0;
    logic       fell = 1'b0;
    logic       time_elapsed = 1'b0;
    logic       start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en;
    logic       jump_left_out, jump_right_out, time_bar_start, points_clr, bg_color_select;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    game_controller dut (
        .clk(clk), .rst(rst), .start_tick(start_tick),
        .jump_left_in(jump_left_in), .jump_right_in(jump_right_in),
        .one_ms_tick(one_ms_tick), .landed(landed), .fell(fell),
        .time_elapsed(time_elapsed),
        .start_screen_en(start_screen_en), .blocks_en(blocks_en),
        .time_bar_en(time_bar_en), .character_en(character_en),
        .points_en(points_en), .end_screen_en(end_screen_en),
        .jump_left_out(jump_left_out), .jump_right_out(jump_right_out),
        .time_bar_start(time_bar_start), .points_clr(points_clr),
        .bg_color_select(bg_color_select), .state(state)
    );

    // ---------------- clock ----------------
    always #12 clk = ~clk;

    // ---------------- model ----------------
    // Game rules written against plain integers: phase, ms elapsed in phase,
    // landings since the last colour flip and the current colour.
    int   m_phase = 0;
    int   m_ms = 0;
    int   m_lands = 0;
    logic m_bg = 1'b0;
    logic [13:0] exp_q[$];

    function automatic logic [5:0] phase_enables(input int p);
        // {start_screen, blocks, time_bar, character, points, end_screen}
        if (p == 1) return 6'b010110;
        if (p == 2 || p == 3) return 6'b011110;
        if (p == 4) return 6'b000011;
        return 6'b100000;
    endfunction

    always @(posedge clk) begin
        int   next_phase;
        logic e_jl, e_jr, e_tbs, e_clr;
        next_phase = m_phase;
        e_jl = 0; e_jr = 0; e_tbs = 0; e_clr = 0;
        if (!rst) begin
            m_phase = 0; m_ms = 0; m_lands = 0; m_bg = 0;
        end else begin
            if (m_phase == 0 && start_tick) begin
                next_phase = 1; e_clr = 1;
            end else if (m_phase == 1 && m_ms == 500) begin
                next_phase = 2; e_tbs = 1;
            end else if (m_phase == 2) begin
                if (time_elapsed) next_phase = 4;
                else if (jump_left_in != jump_right_in) begin
                    next_phase = 3; e_jl = jump_left_in; e_jr = jump_right_in;
                end
            end else if (m_phase == 3) begin
                if (fell) next_phase = 4;
                else if (landed) begin
                    next_phase = 2; e_tbs = 1;
                    m_lands = m_lands + 1;
                    if (m_lands == 10) begin m_lands = 0; m_bg = ~m_bg; end
                end
                else if (time_elapsed || m_ms == 1000) next_phase = 4;
            end else if (m_phase == 4 && start_tick && m_ms >= 2000) begin
                next_phase = 0;
            end
            if (m_phase == 1) m_lands = 0;
            if (next_phase != m_phase) m_ms = 0;
            else if (one_ms_tick && m_ms < 65535) m_ms = m_ms + 1;
            m_phase = next_phase;
        end
        exp_q.push_back({3'(m_phase), phase_enables(m_phase), e_jl, e_jr, e_tbs, e_clr, m_bg});
        #1;
        begin
            logic [13:0] got, exp;
            got = {state, start_screen_en, blocks_en, time_bar_en, character_en,
                   points_en, end_screen_en, jump_left_out, jump_right_out,
                   time_bar_start, points_clr, bg_color_select};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got=%b exp=%b", $time, got, exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // p = {start, jl, jr, landed, fell, time_elapsed, tick}; held for one cycle.
    task automatic step(input logic [6:0] p);
        {start_tick, jump_left_in, jump_right_in, landed, fell, time_elapsed, one_ms_tick} = p;
        @(negedge clk);
        {start_tick, jump_left_in, jump_right_in, landed, fell, time_elapsed, one_ms_tick} = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(7'b0000001);
            @(negedge clk);
        end
    endtask

    localparam logic [6:0] P_START = 7'b1000000;
    localparam logic [6:0] P_JL    = 7'b0100000;
    localparam logic [6:0] P_JR    = 7'b0010000;
    localparam logic [6:0] P_LAND  = 7'b0001000;
    localparam logic [6:0] P_FELL  = 7'b0000100;
    localparam logic [6:0] P_TE    = 7'b0000010;
    localparam logic [6:0] P_TICK  = 7'b0000001;

    task automatic start_game();
        step(P_START);
        ticks(500);
    endtask

    // ---------------- directed script ----------------
    initial begin
        repeat (5) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_en", {start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en}, 6'b100000);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_pulses", {jump_left_out, jump_right_out, time_bar_start, points_clr, bg_color_select}, 0);

        step(P_START);
        chk("arm_state", state, 1);
        chk("arm_points_clr", points_clr, 1);
        ticks(499);
        chk("arm_hold_499", state, 1);
        ticks(1);
        chk("play_state", state, 2);
        chk("play_tbs", time_bar_start, 1);

        step(P_JL);
        chk("air_state", state, 3);
        chk("air_jl_out", jump_left_out, 1);
        step(P_JR);
        chk("air_jr_dropped", jump_right_out, 0);
        step(P_LAND);
        chk("land_state", state, 2);
        chk("land_tbs", time_bar_start, 1);

        step(P_JL | P_JR);
        chk("both_jumps_state", state, 2);
        chk("both_jumps_out", {jump_left_out, jump_right_out}, 0);
        step(P_JR);
        chk("jr_out", jump_right_out, 1);
        step(P_LAND | P_TE);
        chk("land_beats_te", state, 2);

        for (int i = 3; i <= 10; i++) begin
            step(P_JL);
            step(P_LAND);
            if (i == 9) chk("bg_before_10th", bg_color_select, 0);
        end
        chk("bg_after_10th", bg_color_select, 1);

        // Tick coinciding with the jump must not count towards the timeout.
        step(P_JL | P_TICK);
        ticks(999);
        chk("air_hold_999", state, 3);
        ticks(1);
        chk("air_timeout", state, 4);
        chk("over_en", {start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en}, 6'b000011);

        ticks(1999);
        step(P_START);
        chk("over_hold_1999", state, 4);
        ticks(1);
        step(P_START);
        chk("over_exit", state, 0);
        chk("bg_kept", bg_color_select, 1);

        // Empty time bar wins over a jump in PLAY.
        start_game();
        step(P_JL | P_TE);
        chk("te_beats_jump", state, 4);
        chk("te_no_jump_out", jump_left_out, 0);

        ticks(2000);
        step(P_START);
        start_game();
        step(P_JR);
        step(P_FELL);
        chk("fell_over", state, 4);

        ticks(2000);
        step(P_START);
        start_game();
        step(P_JL);
        step(P_TE);
        chk("air_te_over", state, 4);

        // Asynchronous reset in the middle of a jump.
        ticks(2000);
        step(P_START);
        start_game();
        jump_left_in = 1'b1;
        @(posedge clk);
        #3;
        jump_left_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_pulses", {jump_left_out, jump_right_out, time_bar_start, points_clr, bg_color_select}, 0);
        chk("async_rst_en", start_screen_en, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("after_rst_state", state, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
